slice_loader: RTL and testbench

- Upstream feeder for the state-array permutation controller.
- Accepts 25-bit lines (one 5x5 slice each) from the input stream over a valid/ready handshake and buffers a full block of DEPTH lines.
- Once the block is full, it issues a one-cycle start pulse to the controller.
- It then returns one registered line per readLine request and tracks the line count the controller compares against, until the controller reports completion.

---
 rtl/slice_loader_pkg.sv | 20 ++
 rtl/slice_buffer.sv | 44 ++++
 rtl/slice_loader.sv | 169 ++++++++++++++++
 tb/tb_slice_loader.sv | 290 +++++++++++++++++++++++++++++
 4 files changed

// File: rtl/slice_loader_pkg.sv
// Shared constants and state encoding for the slice loader and its line buffer.
package slice_loader_pkg;

  // Lane dimension; one line carries a SIZE x SIZE slice.
  localparam int SIZE    = 5;
  // Line width in bits; must equal SIZE*SIZE.
  localparam int MEMSIZE = 25;
  // Lines per block; a power of two, at most 2**CW.
  localparam int DEPTH   = 64;
  // Width of the pointers and of the count output.
  localparam int CW      = 6;

  // Loader states. The unused code 2'd3 is steered back to FILL.
  typedef enum logic [1:0] {
    FILL  = 2'd0,
    KICK  = 2'd1,
    SERVE = 2'd2
  } state_e;

endpackage

// File: rtl/slice_buffer.sv
// Block buffer for the slice loader: single-write, single-read register file
// with a registered read port. The read register holds its value whenever no
// read is issued, so it can drive the loader's line output directly.
module slice_buffer
  import slice_loader_pkg::*;
#(
  parameter int WIDTH   = slice_loader_pkg::MEMSIZE,
  parameter int ENTRIES = slice_loader_pkg::DEPTH,
  parameter int AW      = slice_loader_pkg::CW
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             wr_en,
  input  logic [AW-1:0]    wr_addr,
  input  logic [WIDTH-1:0] wr_data,
  input  logic             rd_en,
  input  logic [AW-1:0]    rd_addr,
  output logic [WIDTH-1:0] rd_data
);

  logic [WIDTH-1:0] mem_r [ENTRIES];
  logic [WIDTH-1:0] rd_data_r;

  // Storage write; contents are don't-care until written, so no reset.
  always_ff @(posedge clk) begin
    if (wr_en) begin
      mem_r[wr_addr] <= wr_data;
    end
  end

  // Registered read port; holds its last value when no read is issued.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      rd_data_r <= {WIDTH{1'b0}};
    end else if (rd_en) begin
      rd_data_r <= mem_r[rd_addr];
    end else begin
      rd_data_r <= rd_data_r;
    end
  end

  assign rd_data = rd_data_r;

endmodule

// File: rtl/slice_loader.sv
// Upstream feeder for the state-array permutation controller. It collects a
// block of DEPTH lines, pulses start once the block is complete, then hands
// lines out one per readLine until the controller signals finish.
module slice_loader
  import slice_loader_pkg::*;
#(
  parameter int SIZE    = slice_loader_pkg::SIZE,
  parameter int MEMSIZE = slice_loader_pkg::MEMSIZE,
  parameter int DEPTH   = slice_loader_pkg::DEPTH,
  parameter int CW      = slice_loader_pkg::CW
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               in_valid,
  input  logic [MEMSIZE-1:0] in_data,
  output logic               in_ready,
  output logic               start,
  input  logic               readLine,
  output logic [MEMSIZE-1:0] line,
  output logic [CW-1:0]      count,
  input  logic               finish,
  output logic               busy,
  output logic               overread
);

  // The line must carry exactly one SIZE x SIZE slice.
  if (MEMSIZE != SIZE * SIZE) begin : g_bad_line_width
    $error("slice_loader: MEMSIZE must equal SIZE*SIZE");
  end

  // Pointers and count are one bit wider than the buffer index, so the value
  // DEPTH (block exhausted) is representable without wrapping.
  localparam logic [CW:0] DEPTH_W = (CW+1)'(DEPTH);
  localparam logic [CW:0] LAST_W  = (CW+1)'(DEPTH - 1);
  localparam logic [CW:0] ONE_W   = (CW+1)'(1);
  localparam logic [CW:0] ZERO_W  = (CW+1)'(0);

  state_e             state_r;
  logic [CW:0]        wr_ptr_r;
  logic [CW:0]        rd_ptr_r;
  logic [CW:0]        cnt_r;
  logic               in_ready_r;
  logic               start_r;
  logic               busy_r;
  logic               overread_r;

  logic               accept_s;
  logic               rd_req_s;
  logic               rd_en_s;
  logic               overread_hit_s;
  logic [MEMSIZE-1:0] line_s;

  // Decode the input handshake and the controller's read request; finish
  // takes priority over a same-cycle readLine.
  always_comb begin
    accept_s       = 1'b0;
    rd_req_s       = 1'b0;
    rd_en_s        = 1'b0;
    overread_hit_s = 1'b0;
    if (state_r == FILL) begin
      accept_s = in_valid & in_ready_r;
    end else begin
      accept_s = 1'b0;
    end
    if (state_r == SERVE) begin
      rd_req_s = readLine & ~finish;
    end else begin
      rd_req_s = 1'b0;
    end
    if (rd_ptr_r < DEPTH_W) begin
      rd_en_s        = rd_req_s;
      overread_hit_s = 1'b0;
    end else begin
      rd_en_s        = 1'b0;
      overread_hit_s = rd_req_s;
    end
  end

  // Block sequencing FSM with its pointers, count and registered flags.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_r    <= FILL;
      wr_ptr_r   <= ZERO_W;
      rd_ptr_r   <= ZERO_W;
      cnt_r      <= ZERO_W;
      in_ready_r <= 1'b0;
      start_r    <= 1'b0;
      busy_r     <= 1'b0;
      overread_r <= 1'b0;
    end else begin
      start_r <= 1'b0;
      case (state_r)
        FILL: begin
          if (accept_s) begin
            wr_ptr_r <= wr_ptr_r + ONE_W;
            if (wr_ptr_r == LAST_W) begin
              state_r    <= KICK;
              in_ready_r <= 1'b0;
              start_r    <= 1'b1;
              busy_r     <= 1'b1;
            end else begin
              in_ready_r <= 1'b1;
            end
          end else begin
            in_ready_r <= 1'b1;
          end
        end
        KICK: begin
          state_r    <= SERVE;
          in_ready_r <= 1'b0;
        end
        SERVE: begin
          if (finish) begin
            state_r    <= FILL;
            wr_ptr_r   <= ZERO_W;
            rd_ptr_r   <= ZERO_W;
            cnt_r      <= ZERO_W;
            busy_r     <= 1'b0;
            in_ready_r <= 1'b1;
          end else if (rd_en_s) begin
            rd_ptr_r   <= rd_ptr_r + ONE_W;
            in_ready_r <= 1'b0;
            if (cnt_r < DEPTH_W) begin
              cnt_r <= cnt_r + ONE_W;
            end else begin
              cnt_r <= cnt_r;
            end
          end else if (overread_hit_s) begin
            overread_r <= 1'b1;
            in_ready_r <= 1'b0;
          end else begin
            in_ready_r <= 1'b0;
          end
        end
        default: begin
          state_r    <= FILL;
          wr_ptr_r   <= ZERO_W;
          rd_ptr_r   <= ZERO_W;
          cnt_r      <= ZERO_W;
          busy_r     <= 1'b0;
          in_ready_r <= 1'b0;
        end
      endcase
    end
  end

  slice_buffer #(
    .WIDTH   (MEMSIZE),
    .ENTRIES (DEPTH),
    .AW      (CW)
  ) u_buffer (
    .clk     (clk),
    .rst     (rst),
    .wr_en   (accept_s),
    .wr_addr (wr_ptr_r[CW-1:0]),
    .wr_data (in_data),
    .rd_en   (rd_en_s),
    .rd_addr (rd_ptr_r[CW-1:0]),
    .rd_data (line_s)
  );

  assign in_ready = in_ready_r;
  assign start    = start_r;
  assign line     = line_s;
  assign count    = cnt_r[CW-1:0];
  assign busy     = busy_r;
  assign overread = overread_r;

endmodule

// File: tb/tb_slice_loader.sv
// Self-checking bench for slice_loader. The reference model is a queue of
// lines the bench expects the block to hold plus a count of lines handed out.
module tb_slice_loader;

  localparam int MW  = 25;
  localparam int D   = 64;
  localparam int CWL = 6;

  logic           clk = 1'b0;
  logic           rst = 1'b0;
  logic           in_valid = 1'b0;
  logic [MW-1:0]  in_data = '0;
  logic           readLine = 1'b0;
  logic           finish = 1'b0;
  logic           in_ready;
  logic           start;
  logic [MW-1:0]  line;
  logic [CWL-1:0] count;
  logic           busy;
  logic           overread;

  int checks = 0;
  int errors = 0;

  // Reference model state.
  logic [MW-1:0] blk [D];       // lines the bench intends to load next
  logic [MW-1:0] stored [$];    // lines the current block should hold, in order
  int            served;        // lines handed out in the current block
  bit            model_over;    // sticky over-read expectation
  logic [MW-1:0] exp_line;      // line the DUT should be presenting

  slice_loader dut (
    .clk      (clk),
    .rst      (rst),
    .in_valid (in_valid),
    .in_data  (in_data),
    .in_ready (in_ready),
    .start    (start),
    .readLine (readLine),
    .line     (line),
    .count    (count),
    .finish   (finish),
    .busy     (busy),
    .overread (overread)
  );

  always #5 clk = ~clk;

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog expired");
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Load blk[] as one block. mode 0: valid every cycle, 1: every other cycle, 2: random.
  task automatic fill_block(input int mode, input string tag);
    int acc = 0;
    int cyc = 0;
    int wc  = 0;
    bit v;
    bit rdy;
    stored.delete();
    while (in_ready !== 1'b1 && wc < 20) begin
      tick();
      wc++;
    end
    checks++;
    if (in_ready !== 1'b1) begin
      errors++;
      $display("FAIL %s_ready_wait: in_ready=%b required 1", tag, in_ready);
    end
    while (acc < D && cyc < 2000) begin
      case (mode)
        0: v = 1'b1;
        1: v = (cyc % 2 == 0);
        default: v = 1'($urandom_range(0, 1));
      endcase
      in_valid = v;
      in_data  = blk[acc];
      rdy      = (in_ready === 1'b1);
      checks++;
      if (start !== 1'b0) begin
        errors++;
        $display("FAIL %s_early_start: start=%b required 0 after %0d lines", tag, start, acc);
      end
      if (mode == 0) begin
        checks++;
        if (in_ready !== 1'b1) begin
          errors++;
          $display("FAIL %s_ready_hold: in_ready=%b required 1 after %0d lines", tag, in_ready, acc);
        end
      end
      tick();
      cyc++;
      if (v && rdy) begin
        stored.push_back(blk[acc]);
        acc++;
      end
    end
    in_valid = 1'b0;
    checks++;
    if (acc != D) begin
      errors++;
      $display("FAIL %s_fill_timeout: accepted %0d lines required %0d", tag, acc, D);
    end
    checks++;
    if (start !== 1'b1 || busy !== 1'b1 || in_ready !== 1'b0) begin
      errors++;
      $display("FAIL %s_kick: start/busy/in_ready=%b%b%b required 110", tag, start, busy, in_ready);
    end
    // Data offered outside FILL must be dropped.
    in_valid = 1'b1;
    in_data  = MW'($urandom);
    tick();
    in_valid = 1'b0;
    checks++;
    if (start !== 1'b0 || busy !== 1'b1 || in_ready !== 1'b0) begin
      errors++;
      $display("FAIL %s_post_kick: start/busy/in_ready=%b%b%b required 010", tag, start, busy, in_ready);
    end
    served = 0;
  endtask

  // Issue n back-to-back readLine requests and check each returned line.
  task automatic read_lines(input int n, input string tag);
    for (int i = 0; i < n; i++) begin
      readLine = 1'b1;
      tick();
      if (served < D) begin
        exp_line = stored[served];
        served++;
      end else begin
        model_over = 1'b1;
      end
      checks++;
      if (line !== exp_line) begin
        errors++;
        $display("FAIL %s_line[%0d]: line=%0d required %0d", tag, i, line, exp_line);
      end
      checks++;
      if (count !== CWL'(served % D)) begin
        errors++;
        $display("FAIL %s_count[%0d]: count=%0d required %0d", tag, i, count, served % D);
      end
      checks++;
      if (overread !== model_over || start !== 1'b0) begin
        errors++;
        $display("FAIL %s_flags[%0d]: overread/start=%b%b required %b0", tag, i, overread, start, model_over);
      end
    end
    readLine = 1'b0;
  endtask

  // Pulse finish, optionally together with readLine, and check the return to FILL.
  task automatic do_finish(input bit with_read, input string tag);
    finish   = 1'b1;
    readLine = with_read;
    tick();
    finish   = 1'b0;
    readLine = 1'b0;
    served   = 0;
    checks++;
    if (count !== CWL'(0) || busy !== 1'b0 || in_ready !== 1'b1) begin
      errors++;
      $display("FAIL %s_state: count/busy/in_ready=%0d/%b/%b required 0/0/1", tag, count, busy, in_ready);
    end
    checks++;
    if (line !== exp_line) begin
      errors++;
      $display("FAIL %s_line_hold: line=%0d required %0d", tag, line, exp_line);
    end
    checks++;
    if (overread !== model_over) begin
      errors++;
      $display("FAIL %s_overread: overread=%b required %b", tag, overread, model_over);
    end
  endtask

  task automatic test_reset();
    rst = 1'b0;
    tick();
    tick();
    exp_line   = '0;
    model_over = 1'b0;
    served     = 0;
    checks++;
    if (in_ready !== 1'b0 || start !== 1'b0 || busy !== 1'b0 || overread !== 1'b0 ||
        line !== '0 || count !== CWL'(0)) begin
      errors++;
      $display("FAIL reset_values: rdy/st/busy/ovr=%b%b%b%b line=%0d count=%0d required 0000 0 0",
               in_ready, start, busy, overread, line, count);
    end
    rst = 1'b1;
    tick();
    checks++;
    if (in_ready !== 1'b1) begin
      errors++;
      $display("FAIL reset_release: in_ready=%b required 1", in_ready);
    end
  endtask

  task automatic test_fill();
    for (int k = 0; k < D; k++) blk[k] = MW'(k);
    fill_block(0, "fill");
  endtask

  task automatic test_serve();
    read_lines(D, "serve");
  endtask

  task automatic test_overread();
    read_lines(1, "overread");
    do_finish(1'b0, "finish_after_overread");
  endtask

  task automatic test_backpressure_fill();
    for (int k = 0; k < D; k++) blk[k] = MW'($urandom);
    fill_block(1, "bp_fill");
  endtask

  task automatic test_finish_with_read();
    read_lines(10, "pre_finish");
    do_finish(1'b1, "finish_with_read");
    // A finish outside SERVE must have no effect.
    finish = 1'b1;
    tick();
    finish = 1'b0;
    checks++;
    if (in_ready !== 1'b1 || busy !== 1'b0 || start !== 1'b0) begin
      errors++;
      $display("FAIL finish_in_fill: in_ready/busy/start=%b%b%b required 100", in_ready, busy, start);
    end
    for (int k = 0; k < D; k++) blk[k] = MW'(100 + k);
    fill_block(2, "second_block");
    read_lines(D, "second_serve");
    do_finish(1'b0, "second_finish");
  endtask

  task automatic test_async_reset();
    int acc = 0;
    int cyc = 0;
    bit rdy;
    for (int k = 0; k < D; k++) blk[k] = MW'($urandom);
    while (acc < 20 && cyc < 200) begin
      in_valid = 1'b1;
      in_data  = blk[acc];
      rdy      = (in_ready === 1'b1);
      tick();
      cyc++;
      if (rdy) acc++;
    end
    in_valid = 1'b0;
    #2;
    rst = 1'b0;
    #1;
    exp_line   = '0;
    model_over = 1'b0;
    served     = 0;
    checks++;
    if (in_ready !== 1'b0 || busy !== 1'b0 || overread !== 1'b0 || line !== '0 ||
        count !== CWL'(0) || start !== 1'b0) begin
      errors++;
      $display("FAIL async_reset: rdy/busy/ovr/st=%b%b%b%b line=%0d count=%0d required 0000 0 0",
               in_ready, busy, overread, start, line, count);
    end
    tick();
    rst = 1'b1;
    for (int k = 0; k < D; k++) blk[k] = MW'($urandom);
    fill_block(2, "refill");
    read_lines(D, "refill_serve");
  endtask

  initial begin
    test_reset();
    test_fill();
    test_serve();
    test_overread();
    test_backpressure_fill();
    test_finish_with_read();
    test_async_reset();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
